// File: rtl/game_pkg.sv
// game_pkg: shared tile, map geometry, start cells and trail FSM state types
package game_pkg;
  typedef enum logic [1:0] {EMPTY, WALL, TRAIL_1, TRAIL_2} tile_t;
  typedef enum logic [1:0] {CLEAR, IDLE, ARM, RUN} map_trail_state;
  localparam int MAP_WIDTH = 16;
  localparam int MAP_HEIGHT = 16;
  localparam int XW = $clog2(MAP_WIDTH);
  localparam int YW = $clog2(MAP_HEIGHT);
  localparam logic [7:0] start_x_1 = 8'd4;
  localparam logic [7:0] start_y_1 = 8'd6;
  localparam logic [7:0] start_x_2 = 8'd11;
  localparam logic [7:0] start_y_2 = 8'd6;
endpackage

// File: rtl/map_clear_scan.sv
// map_clear_scan: x-major cell index walker with last-cell pulse and border flag
module map_clear_scan
  import game_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          done,
  output logic          border
);
  logic last_x, last_y;
  assign last_x = x == XW'(MAP_WIDTH - 1);
  assign last_y = y == YW'(MAP_HEIGHT - 1);
  assign done = en && last_x && last_y;
  assign border = x == '0 || last_x || y == '0 || last_y;
  // advance y every cycle, carry into x at the end of each column
  always_ff @(posedge clk)
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      y <= last_y ? '0 : y + 1'b1;
      x <= last_y ? (last_x ? '0 : x + 1'b1) : x;
    end
endmodule

// File: rtl/map_trail.sv
// map_trail: owns the tile map, stamps player trails and flags crashes
module map_trail
  import game_pkg::*;
#(
  parameter bit BORDER_WALL = 1'b1,
  parameter int LEN_W = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [1:0]                                  selected_player,
  input  logic                                        clear_req,
  input  logic [7:0]                                  current_x_1,
  input  logic [7:0]                                  current_y_1,
  input  logic [7:0]                                  current_x_2,
  input  logic [7:0]                                  current_y_2,
  output tile_t [MAP_WIDTH-1:0][MAP_HEIGHT-1:0]       map,
  output logic                                        busy,
  output logic                                        crash_1,
  output logic                                        crash_2,
  output logic [LEN_W-1:0]                            trail_len_1,
  output logic [LEN_W-1:0]                            trail_len_2
);
  map_trail_state state, nxt;
  logic [7:0] px1, py1, px2, py2;
  logic [XW-1:0] sx, xi1, xi2;
  logic [YW-1:0] sy, yi1, yi2;
  logic done, border, go_clr;
  logic mv1, mv2, oob1, oob2, hit1, hit2, wr1, wr2, cr1, cr2;
  map_clear_scan u_scan (
    .clk(clk), .rst(rst || state != CLEAR || clear_req), .en(state == CLEAR),
    .x(sx), .y(sy), .done(done), .border(border)
  );
  assign busy = state == CLEAR;
  assign xi1 = current_x_1[XW-1:0];
  assign yi1 = current_y_1[YW-1:0];
  assign xi2 = current_x_2[XW-1:0];
  assign yi2 = current_y_2[YW-1:0];
  // collision checks read the pre-write map; player 1 wins a shared target
  always_comb begin
    mv1 = state == RUN && !crash_1 && {current_x_1, current_y_1} != {px1, py1};
    mv2 = state == RUN && !crash_2 && {current_x_2, current_y_2} != {px2, py2};
    oob1 = current_x_1 >= 8'(MAP_WIDTH) || current_y_1 >= 8'(MAP_HEIGHT);
    oob2 = current_x_2 >= 8'(MAP_WIDTH) || current_y_2 >= 8'(MAP_HEIGHT);
    hit1 = map[xi1][yi1] != EMPTY && !(current_x_1 == start_x_1 && current_y_1 == start_y_1);
    hit2 = map[xi2][yi2] != EMPTY && !(current_x_2 == start_x_2 && current_y_2 == start_y_2);
    wr1 = mv1 && !oob1 && !hit1;
    wr2 = mv2 && !oob2 && !hit2 && !(wr1 && {current_x_1, current_y_1} == {current_x_2, current_y_2});
    cr1 = mv1 && !wr1;
    cr2 = mv2 && !wr2;
  end
  // next state: clear runs to completion, game runs until deselect or restart
  always_comb begin
    nxt = state == CLEAR ? (done && !clear_req ? IDLE : CLEAR) :
          state == IDLE  ? (selected_player[0] ? ARM : IDLE) :
          state == ARM   ? RUN :
          (!selected_player[0] || clear_req ? CLEAR : RUN);
    go_clr = state == RUN && nxt == CLEAR;
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? CLEAR : nxt;
  // crash flags, trail lengths and last-seen coordinates
  always_ff @(posedge clk)
    if (rst || go_clr) begin
      crash_1 <= 1'b0;
      crash_2 <= 1'b0;
      trail_len_1 <= '0;
      trail_len_2 <= '0;
    end else if (state == ARM) begin
      trail_len_1 <= LEN_W'(1);
      trail_len_2 <= LEN_W'(1);
      {px1, py1} <= {current_x_1, current_y_1};
      {px2, py2} <= {current_x_2, current_y_2};
    end else begin
      if (mv1) {px1, py1} <= {current_x_1, current_y_1};
      if (mv2) {px2, py2} <= {current_x_2, current_y_2};
      if (cr1) crash_1 <= 1'b1;
      if (cr2) crash_2 <= 1'b1;
      if (wr1) trail_len_1 <= trail_len_1 + LEN_W'(trail_len_1 != '1);
      if (wr2) trail_len_2 <= trail_len_2 + LEN_W'(trail_len_2 != '1);
    end
  // tile writes: sequential clear, start stamps, trail stamps
  always_ff @(posedge clk)
    if (state == CLEAR) map[sx][sy] <= BORDER_WALL && border ? WALL : EMPTY;
    else if (state == ARM) begin
      map[XW'(start_x_1)][YW'(start_y_1)] <= TRAIL_1;
      map[XW'(start_x_2)][YW'(start_y_2)] <= TRAIL_2;
    end else begin
      if (wr1) map[xi1][yi1] <= TRAIL_1;
      if (wr2) map[xi2][yi2] <= TRAIL_2;
    end
endmodule

// File: tb/tb_map_trail.sv
// tb_map_trail: directed vector table plus restart/collision sequences for map_trail
module tb_map_trail;
  import game_pkg::*;
  logic clk = 1'b0, rst = 1'b1, clear_req = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [7:0] x1 = 8'd0, y1 = 8'd0, x2 = 8'd0, y2 = 8'd0;
  tile_t [MAP_WIDTH-1:0][MAP_HEIGHT-1:0] map;
  logic busy, crash_1, crash_2;
  logic [15:0] len1, len2;
  int checks = 0, errors = 0;
  typedef struct {
    logic [7:0] x1, y1, x2, y2;
    int c1, c2, l1, l2;
    logic [3:0] cx, cy;
    tile_t ct;
  } vec_t;
  vec_t v[9];

  map_trail #(.BORDER_WALL(1'b1), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .selected_player(sel), .clear_req(clear_req),
    .current_x_1(x1), .current_y_1(y1), .current_x_2(x2), .current_y_2(y2),
    .map(map), .busy(busy), .crash_1(crash_1), .crash_2(crash_2),
    .trail_len_1(len1), .trail_len_2(len2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(input string nm);
    int n = 0;
    while (busy && n < 1000) begin
      step();
      n++;
    end
    chk(nm, n, MAP_WIDTH * MAP_HEIGHT);
  endtask

  task automatic restart(input string nm);
    x1 = start_x_1; y1 = start_y_1; x2 = start_x_2; y2 = start_y_2;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    chk({nm, "_busy"}, busy, 1);
    chk({nm, "_crash"}, {crash_1, crash_2}, 0);
    chk({nm, "_len"}, {len1, len2}, 0);
    wait_clear({nm, "_clear_len"});
    step();
    step();
    chk({nm, "_arm_len1"}, len1, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    v[0] = '{8'd5,  8'd6, 8'd11, 8'd6,  0, 0, 2, 1, 4'd5,  4'd6,  TRAIL_1};
    v[1] = '{8'd6,  8'd6, 8'd11, 8'd6,  0, 0, 3, 1, 4'd6,  4'd6,  TRAIL_1};
    v[2] = '{8'd7,  8'd6, 8'd11, 8'd6,  0, 0, 4, 1, 4'd7,  4'd6,  TRAIL_1};
    v[3] = '{8'd6,  8'd6, 8'd11, 8'd6,  1, 0, 4, 1, 4'd6,  4'd6,  TRAIL_1};
    v[4] = '{8'd8,  8'd6, 8'd11, 8'd6,  1, 0, 4, 1, 4'd8,  4'd6,  EMPTY};
    v[5] = '{8'd8,  8'd6, 8'd11, 8'd7,  1, 0, 4, 2, 4'd11, 4'd7,  TRAIL_2};
    v[6] = '{8'd8,  8'd6, 8'd11, 8'd6,  1, 0, 4, 3, 4'd11, 4'd6,  TRAIL_2};
    v[7] = '{8'd8,  8'd6, 8'd11, 8'd15, 1, 1, 4, 3, 4'd11, 4'd15, WALL};
    v[8] = '{8'd8,  8'd6, 8'd11, 8'd14, 1, 1, 4, 3, 4'd11, 4'd14, EMPTY};

    repeat (3) step();
    chk("rst_busy", busy, 1);
    chk("rst_crash", {crash_1, crash_2}, 0);
    chk("rst_len", {len1, len2}, 0);
    rst = 1'b0;
    wait_clear("init_clear_len");
    chk("wall_0_5", map[0][5], WALL);
    chk("empty_1_1", map[1][1], EMPTY);
    chk("wall_15_15", map[15][15], WALL);
    chk("empty_start", map[4][6], EMPTY);
    chk("post_clear_flags", {crash_1, crash_2, len1, len2}, 0);

    x1 = start_x_1; y1 = start_y_1; x2 = start_x_2; y2 = start_y_2;
    sel = 2'b01;
    step();
    step();
    chk("arm_stamp1", map[4][6], TRAIL_1);
    chk("arm_stamp2", map[11][6], TRAIL_2);
    chk("arm_len1", len1, 1);
    chk("arm_len2", len2, 1);

    for (int i = 0; i < 9; i++) begin
      x1 = v[i].x1; y1 = v[i].y1; x2 = v[i].x2; y2 = v[i].y2;
      step();
      chk($sformatf("vec%0d_crash1", i), crash_1, v[i].c1);
      chk($sformatf("vec%0d_crash2", i), crash_2, v[i].c2);
      chk($sformatf("vec%0d_len1", i), len1, v[i].l1);
      chk($sformatf("vec%0d_len2", i), len2, v[i].l2);
      chk($sformatf("vec%0d_cell", i), map[v[i].cx][v[i].cy], v[i].ct);
    end

    restart("r1");
    x1 = 8'd255;
    step();
    chk("uflow_crash1", crash_1, 1);
    chk("uflow_len1", len1, 1);
    chk("uflow_wall_0_6", map[0][6], WALL);
    chk("uflow_wall_15_6", map[15][6], WALL);

    restart("r2");
    x1 = 8'(MAP_WIDTH - 1);
    step();
    chk("wall_crash1", crash_1, 1);
    chk("wall_len1", len1, 1);
    chk("wall_cell", map[15][6], WALL);

    restart("r3");
    x1 = 8'd8; y1 = 8'd6; x2 = 8'd8; y2 = 8'd6;
    step();
    chk("same_cell", map[8][6], TRAIL_1);
    chk("same_crash1", crash_1, 0);
    chk("same_crash2", crash_2, 1);
    chk("same_len1", len1, 2);
    chk("same_len2", len2, 1);
    for (int y = 7; y <= 11; y++) begin
      y1 = 8'(y);
      step();
    end
    chk("run_len1", len1, 7);
    chk("run_crash2", crash_2, 1);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    chk("creq_busy", busy, 1);
    chk("creq_len", {len1, len2}, 0);
    chk("creq_crash", {crash_1, crash_2}, 0);
    wait_clear("creq_clear_len");
    chk("creq_empty_8_6", map[8][6], EMPTY);
    chk("creq_empty_8_11", map[8][11], EMPTY);
    chk("creq_empty_4_6", map[4][6], EMPTY);
    chk("creq_empty_11_6", map[11][6], EMPTY);
    chk("creq_wall_0_0", map[0][0], WALL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
